// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, strips F0/E0 prefixes, and pulses valid/done/reset/frame_err.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with a failing odd-parity check are rejected.
module ps2_key_rx #(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic [7:0] ps2_data_o,
   output logic       ps2_valid_o,
   output logic       ps2_done_o,
   output logic       ps2_reset_o,
   output logic       frame_err_o
);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

   state_t                 state_reg;
   logic [SYNC_STAGES-1:0] clk_sync_reg;
   logic [SYNC_STAGES-1:0] dat_sync_reg;
   logic                   clk_prev_reg;
   logic [7:0]             shift_reg;
   logic [2:0]             bitcnt_reg;
   logic                   par_reg;
   logic [TW-1:0]          tcnt_reg;
   logic                   brk_reg;
   logic                   ext_reg;

   logic clk_s;
   logic dat_s;
   logic fall;
   logic timeout;
   logic parity_ok;

   assign clk_s   = clk_sync_reg[SYNC_STAGES-1];
   assign dat_s   = dat_sync_reg[SYNC_STAGES-1];
   assign fall    = clk_prev_reg & ~clk_s;
   assign timeout = (state_reg != IDLE) && (tcnt_reg == TCNT_LAST);

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^{shift_reg, par_reg};
`else
   // Parity bit is still captured but never rejects a frame in this build.
   assign parity_ok = (^{shift_reg, par_reg}) | 1'b1;
`endif

   // Synchronisers preset high so reset looks like an idle bus (no false fall).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync_reg <= '1;
         dat_sync_reg <= '1;
         clk_prev_reg <= 1'b1;
      end else begin
         clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk_i};
         dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2_dat_i};
         clk_prev_reg <= clk_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         shift_reg   <= 8'h00;
         bitcnt_reg  <= 3'd0;
         par_reg     <= 1'b0;
         tcnt_reg    <= '0;
         brk_reg     <= 1'b0;
         ext_reg     <= 1'b0;
         ps2_data_o  <= 8'h00;
         ps2_valid_o <= 1'b0;
         ps2_done_o  <= 1'b0;
         ps2_reset_o <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         ps2_valid_o <= 1'b0;
         ps2_done_o  <= 1'b0;
         ps2_reset_o <= 1'b0;
         frame_err_o <= 1'b0;

         if (timeout) begin
            // Timeout takes priority over a coincident falling edge.
            state_reg   <= IDLE;
            tcnt_reg    <= '0;
            frame_err_o <= 1'b1;
         end else begin
            if (state_reg == IDLE || fall)
               tcnt_reg <= '0;
            else
               tcnt_reg <= tcnt_reg + 1'b1;

            if (fall) begin
               case (state_reg)
                  IDLE: begin
                     if (!dat_s) begin
                        state_reg  <= DATA;
                        bitcnt_reg <= 3'd0;
                     end
                  end
                  DATA: begin
                     shift_reg  <= {dat_s, shift_reg[7:1]};
                     bitcnt_reg <= bitcnt_reg + 3'd1;
                     if (bitcnt_reg == 3'd7)
                        state_reg <= PAR;
                  end
                  PAR: begin
                     par_reg   <= dat_s;
                     state_reg <= STOP;
                  end
                  STOP: begin
                     state_reg <= IDLE;
                     if (!dat_s || !parity_ok) begin
                        frame_err_o <= 1'b1;
                     end else if (shift_reg == 8'hF0) begin
                        brk_reg <= 1'b1;
                     end else if (shift_reg == 8'hE0) begin
                        ext_reg <= 1'b1;
                     end else if (brk_reg) begin
                        brk_reg <= 1'b0;
                        ext_reg <= 1'b0;
                     end else if (shift_reg == 8'h5A) begin
                        ps2_done_o <= 1'b1;
                        ext_reg    <= 1'b0;
                     end else if (shift_reg == 8'h76 && !ext_reg) begin
                        ps2_reset_o <= 1'b1;
                     end else if (ext_reg) begin
                        ext_reg <= 1'b0;
                     end else begin
                        ps2_data_o  <= shift_reg;
                        ps2_valid_o <= 1'b1;
                     end
                  end
                  default: state_reg <= IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: drives PS/2 frames (100 clk per bit) and checks output pulses against a queue of expected events.
module tb_ps2_key_rx;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic [7:0] ps2_data;
   logic       ps2_valid;
   logic       ps2_done;
   logic       ps2_reset;
   logic       frame_err;

   ps2_key_rx #(.TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .ps2_clk_i   (ps2_clk),
      .ps2_dat_i   (ps2_dat),
      .ps2_data_o  (ps2_data),
      .ps2_valid_o (ps2_valid),
      .ps2_done_o  (ps2_done),
      .ps2_reset_o (ps2_reset),
      .frame_err_o (frame_err)
   );

   always #5 clk = ~clk;

   localparam int K_VALID = 0;
   localparam int K_DONE  = 1;
   localparam int K_RESET = 2;
   localparam int K_ERR   = 3;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] exp_data = 8'h00;
   int         checks = 0;
   int         errors = 0;
   longint     cyc = 0;
   longint     err_cyc = 0;
   longint     last_fall = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input logic [7:0] d);
      if (kind == K_VALID) exp_data = d;
      exp_q.push_back('{kind, exp_data});
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_dat = bits[i];
         repeat (50) @(posedge clk);
         ps2_clk = 1'b0;
         repeat (50) @(posedge clk);
         ps2_clk = 1'b1;
      end
      ps2_dat = 1'b1;
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   task automatic send(input logic [7:0] b, input logic par, input logic stop);
      send_bits({stop, par, b, 1'b0}, 11);
      $display("frame %02h par %0b stop %0b sent at cycle %0d", b, par, stop, cyc);
      repeat (150) @(posedge clk);
   endtask

   task automatic send_good(input logic [7:0] b);
      send(b, odd_par(b), 1'b1);
   endtask

   // Monitor: every output pulse must match the head of the expectation queue.
   logic [3:0] mon_pulses;
   int         mon_kind;
   exp_t       mon_e;
   always @(negedge clk) begin
      if (rst) begin
         mon_pulses = {ps2_valid, ps2_done, ps2_reset, frame_err};
         if (mon_pulses != 4'b0000) begin
            if ($countones(mon_pulses) > 1) check("onehot", $countones(mon_pulses), 1);
            mon_kind = ps2_valid ? K_VALID : ps2_done ? K_DONE : ps2_reset ? K_RESET : K_ERR;
            if (frame_err) err_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("spurious", mon_pulses, 4'b0000);
            end else begin
               mon_e = exp_q.pop_front();
               check("kind", mon_kind, mon_e.kind);
               check("data", ps2_data, mon_e.data);
               $display("pulse kind %0d data %02h at cycle %0d", mon_kind, ps2_data, cyc);
            end
         end
      end
   end

   initial begin
      repeat (5) @(posedge clk);
      #1 check("rst_state", {ps2_data, ps2_valid, ps2_done, ps2_reset, frame_err}, 0);
      @(negedge clk) rst = 1'b1;
      repeat (10) @(posedge clk);

      // Single make code
      push(K_VALID, 8'h1C);
      send_good(8'h1C);

      // Make followed by break pair
      push(K_VALID, 8'h1C);
      send_good(8'h1C);
      send_good(8'hF0);
      send_good(8'h1C);

      // Enter, extended Enter, Esc
      push(K_DONE, 8'h00);
      send_good(8'h5A);
      send_good(8'hE0);
      push(K_DONE, 8'h00);
      send_good(8'h5A);
      push(K_RESET, 8'h00);
      send_good(8'h76);

      // Bad stop bit, then recovery
      push(K_ERR, 8'h00);
      send(8'h1C, odd_par(8'h1C), 1'b0);
      push(K_VALID, 8'h32);
      send_good(8'h32);

      // Truncated frame hits the timeout
      push(K_ERR, 8'h00);
      send_bits({1'b1, odd_par(8'h1C), 8'h1C, 1'b0}, 4);
      last_fall = cyc - 50;
      repeat (1200) @(posedge clk);
      check("tmo_lat", ((err_cyc - last_fall) >= 995 && (err_cyc - last_fall) <= 1015) ? 1 : 0, 1);
      push(K_VALID, 8'h1C);
      send_good(8'h1C);

      // Wrong parity
`ifdef PS2_PARITY_CHECK_EN
      push(K_ERR, 8'h00);
`else
      push(K_VALID, 8'h1C);
`endif
      send(8'h1C, ~odd_par(8'h1C), 1'b1);

      // Reset in the middle of a frame
      send_bits({1'b1, odd_par(8'h1C), 8'h1C, 1'b0}, 6);
      rst = 1'b0;
      #1 check("rst_mid", {ps2_data, ps2_valid, ps2_done, ps2_reset, frame_err}, 0);
      exp_data = 8'h00;
      repeat (20) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      repeat (20) @(posedge clk);
      push(K_VALID, 8'h1C);
      send_good(8'h1C);

      repeat (200) @(posedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
